// File: rtl/mem_fifo_ctrl_256_64_if.sv
// Stream and memory-macro bundle for mem_fifo_ctrl_256_64.
// master = controller side, slave = producer/consumer/memory side.
interface mem_fifo_ctrl_256_64_if #(
  parameter int AW = 8,
  parameter int DW = 64
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [AW:0]   count;

  modport master (
    input  in_valid, in_data,
    input  out_ready, mem_rdata,
    output in_ready, out_valid, out_data,
    output mem_we, mem_waddr, mem_wdata,
    output mem_re, mem_raddr, count
  );

  modport slave (
    output in_valid, in_data,
    output out_ready, mem_rdata,
    input  in_ready, out_valid, out_data,
    input  mem_we, mem_waddr, mem_wdata,
    input  mem_re, mem_raddr, count
  );
endinterface

// File: rtl/mem_fifo_ctrl_256_64.sv
// FWFT FIFO controller over an external 256x64 registered-read RAM.
// A 2-entry output buffer hides the one-cycle read latency.
module mem_fifo_ctrl_256_64 #(
  parameter int AW    = 8,
  parameter int DW    = 64,
  parameter int DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  mem_fifo_ctrl_256_64_if.master bus
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          inflight;
  logic [DW-1:0] ob0;
  logic [DW-1:0] ob1;
  logic [1:0]    ob_n;
  logic [AW:0]   cnt_q;

  logic          in_rdy;
  logic          ovalid;
  logic          push;
  logic          pop;
  logic          issue;
  logic [1:0]    base;
  logic [1:0]    occ;
  logic          slot;

  assign in_rdy = (mem_cnt != FULL);
  assign ovalid = (ob_n != 2'd0);
  assign push   = bus.in_valid & in_rdy;
  assign pop    = ovalid & bus.out_ready;

  // buffer entries left after this cycle's pop
  assign base  = ob_n - {1'b0, pop};
  assign occ   = base + {1'b0, inflight};
  assign issue = (mem_cnt != '0) &
                 (occ < 2'd2);
  assign slot  = (base != 2'd0);

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = ovalid;
  assign bus.out_data  = ob0;
  assign bus.mem_we    = push;
  assign bus.mem_waddr = wr_ptr;
  assign bus.mem_wdata = bus.in_data;
  assign bus.mem_re    = issue;
  assign bus.mem_raddr = rd_ptr;
  assign bus.count     = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      ob_n     <= 2'd0;
      cnt_q    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
      mem_cnt  <= mem_cnt
                + {{AW{1'b0}}, push}
                - {{AW{1'b0}}, issue};
      inflight <= issue;
      ob_n     <= occ;
      cnt_q    <= cnt_q
                + {{AW{1'b0}}, push}
                - {{AW{1'b0}}, pop};
    end
  end

  // stale read data after reset is dropped since inflight is clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob0 <= '0;
      ob1 <= '0;
    end else begin
      if (pop)
        ob0 <= ob1;
      if (inflight) begin
        unique case (1'b1)
          !slot:   ob0 <= bus.mem_rdata;
          slot:    ob1 <= bus.mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl_256_64.sv
// Randomized bench for mem_fifo_ctrl_256_64 with a queue-based model.
// Includes a behavioural model of the 256x64 registered-read RAM.
module tb_mem_fifo_ctrl_256_64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_fifo_ctrl_256_64_if bus ();

  mem_fifo_ctrl_256_64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] mem [256];

  always @(posedge clk) begin
    if (bus.mem_we)
      mem[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_re)
      bus.mem_rdata <= mem[bus.mem_raddr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // model: ordered words tagged with the edge that accepted them
  typedef struct {
    logic [63:0] d;
    int          t;
  } ent_t;

  ent_t q[$];
  int   ecnt = 0;
  int   wcnt = 0;
  int   rcnt = 0;

  initial begin
    logic acc;
    logic pp;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        wcnt = 0;
        rcnt = 0;
      end else begin
        acc = bus.in_valid && bus.in_ready;
        pp  = bus.out_valid && bus.out_ready;
        ecnt++;
        if (acc) wcnt++;
        if (bus.mem_re) rcnt++;
        if (pp && q.size() > 0)
          void'(q.pop_front());
        if (acc)
          q.push_back('{bus.in_data, ecnt});
      end
    end
  end

  // a word is at the head two edges after it was accepted
  initial begin
    logic exp_v;
    logic coll;
    forever begin
      @(negedge clk);
      exp_v = q.size() > 0 &&
              q[0].t <= ecnt - 2;
      chk("out_valid", bus.out_valid, exp_v);
      if (exp_v)
        chk("out_data", bus.out_data, q[0].d);
      chk("count", bus.count, q.size());
      if (q.size() < 256)
        chk("in_ready_open", bus.in_ready, 1);
      else if (q.size() == 258)
        chk("in_ready_full", bus.in_ready, 0);
      chk("mem_we", bus.mem_we,
          bus.in_valid & bus.in_ready);
      if (bus.mem_we) begin
        chk("mem_waddr", bus.mem_waddr, wcnt % 256);
        chk("mem_wdata", bus.mem_wdata, bus.in_data);
      end
      if (bus.mem_re)
        chk("mem_raddr", bus.mem_raddr, rcnt % 256);
      coll = bus.mem_we && bus.mem_re &&
             bus.mem_waddr == bus.mem_raddr;
      chk("no_collision", coll, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (n) step();
    bus.out_ready = 1'b0;
  endtask

  int idx;
  int popped;
  int bubbles;
  bit started;
  logic acc;
  logic ov;
  logic [63:0] od;
  int pin_t [4] = '{50, 90, 30, 70};
  int pout_t[4] = '{50, 30, 90, 70};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_we", bus.mem_we, 0);
      chk("idle_re", bus.mem_re, 0);
    end

    // single word
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h0000_0000_0000_00A5;
    step();
    bus.in_valid = 1'b0;
    chk("single_k", bus.out_valid, 0);
    step();
    chk("single_k1", bus.out_valid, 0);
    step();
    chk("single_k2", bus.out_valid, 1);
    chk("single_data", bus.out_data, 64'hA5);
    chk("single_count", bus.count, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("single_pop_count", bus.count, 0);
    chk("single_pop_valid", bus.out_valid, 0);

    // fill and drain
    idx = 0;
    for (int c = 0; c < 300; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 64'(idx);
      acc = bus.in_ready;
      step();
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    chk("fill_accepted", idx, 258);
    chk("fill_count", bus.count, 258);
    chk("fill_in_ready", bus.in_ready, 0);
    idx = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (bus.out_valid) begin
        chk("drain_order", bus.out_data, idx);
        idx++;
      end
      step();
    end
    bus.out_ready = 1'b0;
    chk("drain_total", idx, 258);
    chk("drain_count", bus.count, 0);

    // streaming, 1000 words wraps pointers 3+ times
    idx = 0;
    popped = 0;
    bubbles = 0;
    started = 0;
    for (int c = 0; c < 1200 && popped < 1000; c++) begin
      bus.in_valid  = (idx < 1000);
      bus.in_data   = 64'(idx + 5000);
      bus.out_ready = 1'b1;
      ov  = bus.out_valid;
      od  = bus.out_data;
      acc = bus.in_valid && bus.in_ready;
      if (ov) begin
        chk("stream_order", od, popped + 5000);
        popped++;
        started = 1;
      end else if (started) begin
        bubbles++;
      end
      step();
      if (acc) idx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("stream_popped", popped, 1000);
    chk("stream_bubbles", bubbles, 0);

    // random backpressure
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 5000; c++) begin
        bus.in_valid  = $urandom_range(99) < pin_t[p];
        bus.in_data   = {$urandom, $urandom};
        bus.out_ready = $urandom_range(99) < pout_t[p];
        step();
      end
    end
    drain(300);
    chk("random_empty", bus.count, 0);

    // mid-stream asynchronous reset
    for (int i = 0; i < 101; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 64'(i + 100);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (4) step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("mid_count", bus.count, 100);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_re", bus.mem_re, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 64'h1234;
    step();
    bus.in_valid = 1'b0;
    chk("post_k", bus.out_valid, 0);
    step();
    chk("post_k1", bus.out_valid, 0);
    step();
    chk("post_k2", bus.out_valid, 1);
    chk("post_data", bus.out_data, 64'h1234);
    chk("post_count", bus.count, 1);
    drain(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
